if_pc_gen: RTL and testbench
============================

Name: if_pc_gen

Overview:
Program-counter generator for the IF stage. It sits directly upstream of the synchronous instruction memory and drives the byte address that memory reads each clock. The memory returns a 16-bit instruction from bytes pc and pc+1.
- Steps the PC by 2, applies branch redirects, stalls and halts.
- Flags out-of-range fetches.
- Emits fetch_valid and fetch_pc aligned with the memory's registered nibble outputs, so decode can tell real instructions from bubbles.

Parameters:
PC_W, 16, PC/address width in bits
RESET_PC, 0, PC value loaded on reset (must be even)
INC, 2, bytes per instruction
MEM_BYTES, 11, instruction memory depth in bytes; a legal fetch needs pc+1 <= MEM_BYTES-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
stall  input  1  hold PC, suppress new valid fetch (from decode/hazard unit)
br_taken  input  1  redirect request this cycle
br_target  input  PC_W  redirect address; bit 0 ignored (forced to 0)
halt_req  input  1  decode saw halt opcode; stop fetching
resume  input  1  leave HALT, restart at current pc
pc  output  PC_W  address to instruction memory
fetch_valid  output  1  memory outputs this cycle hold a real instruction
fetch_pc  output  PC_W  address of instruction currently on memory outputs
halted  output  1  FSM in HALT
fault  output  1  FSM in FAULT (out-of-range fetch)

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, fetch_valid=0, fetch_pc=0, halted=0, fault=0, state=RUN. Reset mid-operation discards everything immediately.
- Memory samples pc at edge k and presents inst(pc) after edge k.
  - fetch_valid/fetch_pc are registered at the same edge and describe that sample. Zero extra latency vs memory.
- States: RUN, HALT, FAULT. Per-cycle priority in RUN: br_taken > halt_req > stall > normal.
- RUN, normal:
  - pc <= pc+INC, fetch_pc <= pc, fetch_valid <= 1.
  - Out-of-range check: if pc+1 > MEM_BYTES-1, go to FAULT instead, with fetch_valid <= 0 and pc held.
- RUN, br_taken:
  - pc <= {br_target[PC_W-1:1],0}; fetch_valid <= 0 (wrong-path sample squashed). Stall in the same cycle is ignored.
  - Targets past the memory end are accepted; FAULT triggers on the next cycle's range check.
- RUN, halt_req: pc held; fetch_valid <= 0; go to HALT.
- RUN, stall: pc held; fetch_valid <= 0; fetch_pc held.
- HALT: halted=1, pc held, fetch_valid=0.
  - resume -> RUN; first valid fetch is at the held pc.
  - br_taken in HALT: pc <= target, stay in HALT.
  - resume+br_taken together: load target and go to RUN.
- FAULT: fault=1, fetch_valid=0, pc frozen. Exit only by reset; all inputs ignored.
- Arithmetic: pc+INC wraps modulo 2^PC_W (a wrap is caught by the range check first when MEM_BYTES < 2^PC_W).

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_cnt[15:0] and stall_cnt[15:0], both reset to 0.
  - fetch_cnt increments on each edge where fetch_valid is set to 1.
  - stall_cnt increments on each RUN cycle with stall=1 and no br_taken.
  - Both saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
Shared package if_pkg holds:
- state enum {RUN, HALT, FAULT};
- constants PC_W, INC, RESET_PC, MEM_BYTES, so the instruction memory and decode use the same widths and depth.

No sub-module is needed for the core. The optional counters form a natural small sub-module, if_perf_cnt (saturating counter pair).

Test Plan:
- Reset then 4 free-run cycles -> pc 0,2,4,6,8; fetch_valid 0,1,1,1,1; fetch_pc 0,2,4,6.
- stall=1 for 2 cycles at pc=4 -> pc stays 4, fetch_valid=0 both cycles; resumes with fetch_pc=4 and pc=6.
- br_taken with br_target=7 at pc=2, stall=1 in the same cycle -> next pc=6, fetch_valid=0; following cycle fetch_pc=6, fetch_valid=1.
- halt_req at pc=6 -> halted=1, pc=6, fetch_valid=0 for 3 cycles; resume -> fetch_pc=6 valid one cycle later.
- Free-run from 0 with MEM_BYTES=11 -> pc reaches 10, fault=1, pc frozen at 10; inputs ignored until rst pulse restores pc=0, fault=0.
- rst asserted mid-branch (br_taken=1, target=8) -> outputs reset asynchronously and the redirect is lost. With IF_PERF_CNT_EN, counters clear to 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the IF stage: FSM encoding and the fetch-path
// geometry, so instruction memory, decode and the PC generator all agree
// on address width, step size, reset vector and memory depth.
package if_pkg;

    localparam int PC_W      = 16;   // PC / byte-address width
    localparam int RESET_PC  = 0;    // reset vector, must be even
    localparam int INC       = 2;    // bytes per 16-bit instruction
    localparam int MEM_BYTES = 11;   // instruction memory depth in bytes

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/if_perf_cnt.sv
// Bank of independent saturating event counters. Each counter advances by
// one on every clock where its increment strobe is high and sticks at the
// all-ones value instead of wrapping.
module if_perf_cnt #(
    parameter int N = 2,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        inc,
    output logic [N-1:0][W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            logic [W-1:0] cnt_reg;

            // Count one event per strobed cycle, holding at saturation
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + ONE;
                end
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

endmodule

// File: rtl/if_pc_gen.sv
// IF-stage program-counter generator. Drives the byte address of the
// synchronous instruction memory and produces fetch_valid/fetch_pc that line
// up with the memory's registered outputs (both are updated at the edge the
// memory samples pc). Handles branch redirects, stalls, halt/resume and
// traps out-of-range fetches into a sticky FAULT state.
//
// Build option: define IF_PERF_CNT_EN to add the fetch_cnt / stall_cnt
// saturating performance counters.
module if_pc_gen #(
    parameter int PC_W      = if_pkg::PC_W,
    parameter int RESET_PC  = if_pkg::RESET_PC,
    parameter int INC       = if_pkg::INC,
    parameter int MEM_BYTES = if_pkg::MEM_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic [PC_W-1:0] fetch_pc,
    output logic            halted,
    output logic            fault
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]     fetch_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    import if_pkg::*;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] INC_V      = PC_W'(INC);
    // Highest legal byte address, one bit wider than the PC so that the
    // pc+1 comparison cannot itself wrap.
    localparam logic [PC_W:0]   LAST_BYTE  = (PC_W+1)'(MEM_BYTES - 1);
    localparam logic [PC_W:0]   ONE_W      = (PC_W+1)'(1);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic            fetch_valid_reg, fetch_valid_next;

    logic [PC_W-1:0] br_pc;
    logic [PC_W:0]   pc_last_byte;
    logic            in_range;

    // Instructions are halfword aligned: the redirect address drops bit 0.
    assign br_pc        = {br_target[PC_W-1:1], 1'b0};
    // A fetch reads bytes pc and pc+1; both must exist in memory.
    assign pc_last_byte = {1'b0, pc_reg} + ONE_W;
    assign in_range     = (pc_last_byte <= LAST_BYTE);

    // State register: FSM state, PC and the fetch descriptor of the sample
    // the memory is taking at this same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC_V;
            fetch_pc_reg    <= '0;
            fetch_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            fetch_pc_reg    <= fetch_pc_next;
            fetch_valid_reg <= fetch_valid_next;
        end
    end

    // Next-state logic; in RUN the priority is branch > halt > stall > step.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        fetch_pc_next    = fetch_pc_reg;
        fetch_valid_next = 1'b0;
        case (state_reg)
            RUN: begin
                if (br_taken) begin
                    // Wrong-path sample is squashed; range of the new
                    // target is checked on the following cycle.
                    pc_next = br_pc;
                end else if (halt_req) begin
                    state_next = HALT;
                end else if (stall) begin
                    // Hold everything; the bubble keeps fetch_valid low.
                end else if (!in_range) begin
                    state_next = FAULT;
                end else begin
                    pc_next          = pc_reg + INC_V;
                    fetch_pc_next    = pc_reg;
                    fetch_valid_next = 1'b1;
                end
            end
            HALT: begin
                if (br_taken) begin
                    pc_next = br_pc;
                end
                if (resume) begin
                    state_next = RUN;
                end
            end
            FAULT: begin
                // Frozen until reset.
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        pc          = pc_reg;
        fetch_pc    = fetch_pc_reg;
        fetch_valid = fetch_valid_reg;
        halted      = (state_reg == HALT);
        fault       = (state_reg == FAULT);
    end

`ifdef IF_PERF_CNT_EN
    logic [1:0]       cnt_inc;
    logic [1:0][15:0] cnt_val;

    // Counter strobes: a real fetch issued this edge, and a RUN-cycle stall
    // that was not overridden by a redirect.
    always_comb begin
        cnt_inc    = '0;
        cnt_inc[0] = fetch_valid_next;
        cnt_inc[1] = (state_reg == RUN) && stall && !br_taken;
    end

    if_perf_cnt #(
        .N (2),
        .W (16)
    ) u_perf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .cnt (cnt_val)
    );

    assign fetch_cnt = cnt_val[0];
    assign stall_cnt = cnt_val[1];
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// Directed testbench for if_pc_gen: free run, stall, branch with stall,
// halt/resume (including redirects in HALT), out-of-range fault and
// asynchronous reset during a redirect. Expected values are hand-computed.
module tb_if_pc_gen;

    localparam int PC_W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic            br_taken = 1'b0;
    logic [PC_W-1:0] br_target = '0;
    logic            halt_req = 1'b0;
    logic            resume = 1'b0;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic [PC_W-1:0] fetch_pc;
    logic            halted;
    logic            fault;
`ifdef IF_PERF_CNT_EN
    logic [15:0]     fetch_cnt;
    logic [15:0]     stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_pc_gen dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .halted      (halted),
        .fault       (fault)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state in one line.
    task automatic expect_state(input string tag, input logic [15:0] e_pc, input logic e_fv,
                                input logic [15:0] e_fpc, input logic e_halt, input logic e_fault);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
        check({tag, ".fetch_pc"}, 32'(fetch_pc), 32'(e_fpc));
        check({tag, ".halted"}, 32'(halted), 32'(e_halt));
        check({tag, ".fault"}, 32'(fault), 32'(e_fault));
        $display("[%0t] %s pc=%0d fv=%0b fpc=%0d halted=%0b fault=%0b",
                 $time, tag, pc, fetch_valid, fetch_pc, halted, fault);
    endtask

    // Pulse reset between rising edges.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        // ---- reset and free run ----
        step();
        step();
        expect_state("reset", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(); expect_state("run1", 16'd2, 1'b1, 16'd0, 1'b0, 1'b0);
        step(); expect_state("run2", 16'd4, 1'b1, 16'd2, 1'b0, 1'b0);
        step(); expect_state("run3", 16'd6, 1'b1, 16'd4, 1'b0, 1'b0);
        step(); expect_state("run4", 16'd8, 1'b1, 16'd6, 1'b0, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("run.fetch_cnt", 32'(fetch_cnt), 32'd4);
        check("run.stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // ---- stall at pc=4 ----
        pulse_reset();
        expect_state("stall.rst", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        step();
        step(); expect_state("stall.pre", 16'd4, 1'b1, 16'd2, 1'b0, 1'b0);
        stall = 1'b1;
        step(); expect_state("stall1", 16'd4, 1'b0, 16'd2, 1'b0, 1'b0);
        step(); expect_state("stall2", 16'd4, 1'b0, 16'd2, 1'b0, 1'b0);
        stall = 1'b0;
        step(); expect_state("stall.end", 16'd6, 1'b1, 16'd4, 1'b0, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("stall.fetch_cnt", 32'(fetch_cnt), 32'd3);
        check("stall.stall_cnt", 32'(stall_cnt), 32'd2);
`endif

        // ---- branch to 7 with simultaneous stall at pc=2 ----
        pulse_reset();
        step(); expect_state("br.pre", 16'd2, 1'b1, 16'd0, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 16'd7; stall = 1'b1;
        step(); expect_state("br.take", 16'd6, 1'b0, 16'd0, 1'b0, 1'b0);
        br_taken = 1'b0; stall = 1'b0;
        step(); expect_state("br.next", 16'd8, 1'b1, 16'd6, 1'b0, 1'b0);

        // ---- halt at pc=6, resume ----
        pulse_reset();
        step(); step(); step();
        expect_state("halt.pre", 16'd6, 1'b1, 16'd4, 1'b0, 1'b0);
        halt_req = 1'b1;
        step(); expect_state("halt1", 16'd6, 1'b0, 16'd4, 1'b1, 1'b0);
        halt_req = 1'b0;
        step(); expect_state("halt2", 16'd6, 1'b0, 16'd4, 1'b1, 1'b0);
        step(); expect_state("halt3", 16'd6, 1'b0, 16'd4, 1'b1, 1'b0);
        resume = 1'b1;
        step(); expect_state("resume", 16'd6, 1'b0, 16'd4, 1'b0, 1'b0);
        resume = 1'b0;
        step(); expect_state("resume.fetch", 16'd8, 1'b1, 16'd6, 1'b0, 1'b0);
        // branch while halted, then resume together with a branch
        halt_req = 1'b1;
        step(); expect_state("halt.b", 16'd8, 1'b0, 16'd6, 1'b1, 1'b0);
        halt_req = 1'b0; br_taken = 1'b1; br_target = 16'd3;
        step(); expect_state("halt.br", 16'd2, 1'b0, 16'd6, 1'b1, 1'b0);
        br_target = 16'd5; resume = 1'b1;
        step(); expect_state("halt.brres", 16'd4, 1'b0, 16'd6, 1'b0, 1'b0);
        br_taken = 1'b0; resume = 1'b0;
        step(); expect_state("halt.brfetch", 16'd6, 1'b1, 16'd4, 1'b0, 1'b0);

        // ---- out-of-range fault ----
        pulse_reset();
        step(); step(); step(); step();
        step(); expect_state("flt.pre", 16'd10, 1'b1, 16'd8, 1'b0, 1'b0);
        step(); expect_state("flt.trap", 16'd10, 1'b0, 16'd8, 1'b0, 1'b1);
        br_taken = 1'b1; br_target = 16'd4; resume = 1'b1; halt_req = 1'b1;
        step(); expect_state("flt.hold", 16'd10, 1'b0, 16'd8, 1'b0, 1'b1);
        br_taken = 1'b0; resume = 1'b0; halt_req = 1'b0;
        pulse_reset();
        expect_state("flt.rst", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);

        // ---- asynchronous reset during a redirect ----
        step(); step();
        expect_state("arst.pre", 16'd4, 1'b1, 16'd2, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 16'd8;
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_state("arst.async", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("arst.fetch_cnt", 32'(fetch_cnt), 32'd0);
        check("arst.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        step(); expect_state("arst.hold", 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        br_taken = 1'b0;
        step(); expect_state("arst.after", 16'd2, 1'b1, 16'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
